// File: rtl/digi_ota_integrator.sv
// Multi-channel digital OTA: latching comparator or saturating integrator with sigma-delta output.
// Optional DIGI_OTA_DEBOUNCE_EN adds a 3-edge agreement filter in comparator mode.
module digi_ota_integrator #(
    parameter int CHANNELS    = 2,
    parameter int ACC_W       = 8,
    parameter int SYNC_STAGES = 2,
    parameter int STEP        = 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                ena,
    input  logic                mode,
    input  logic [CHANNELS-1:0] vip,
    input  logic [CHANNELS-1:0] vin,
    output logic [CHANNELS-1:0] out,
    output logic [CHANNELS-1:0] out_oe,
    output logic [CHANNELS-1:0] sat
);

    localparam logic [ACC_W-1:0] MID    = {1'b1, {(ACC_W-1){1'b0}}};
    localparam logic [ACC_W:0]   MAX_X  = {1'b0, {ACC_W{1'b1}}};
    localparam logic [ACC_W:0]   STEP_X = (ACC_W+1)'(STEP);

    logic [CHANNELS-1:0] vip_sync_q [SYNC_STAGES];
    logic [CHANNELS-1:0] vin_sync_q [SYNC_STAGES];
    logic [CHANNELS-1:0] vip_s, vin_s;

    logic                mode_q, mode_d;
    logic [ACC_W-1:0]    acc_q [CHANNELS];
    logic [ACC_W-1:0]    acc_d [CHANNELS];
    logic [ACC_W-1:0]    err_q [CHANNELS];
    logic [ACC_W-1:0]    err_d [CHANNELS];
    logic [CHANNELS-1:0] out_q, out_d;
    logic [CHANNELS-1:0] oe_q, oe_d;
    logic [CHANNELS-1:0] sat_q, sat_d;
`ifdef DIGI_OTA_DEBOUNCE_EN
    logic [1:0]          cnt_q [CHANNELS];
    logic [1:0]          cnt_d [CHANNELS];
    logic [CHANNELS-1:0] dir_q, dir_d;
`endif

    assign vip_s  = vip_sync_q[SYNC_STAGES-1];
    assign vin_s  = vin_sync_q[SYNC_STAGES-1];
    assign out    = out_q;
    assign out_oe = oe_q;
    assign sat    = sat_q;

    always_comb begin
        logic           up, dn, diff;
        logic [ACC_W:0] nxt, sd;
`ifdef DIGI_OTA_DEBOUNCE_EN
        logic [1:0]     cnt_n;
`endif
        mode_d = ena ? mode : mode_q;
        for (int c = 0; c < CHANNELS; c++) begin
            up   = vip_s[c] & ~vin_s[c];
            dn   = ~vip_s[c] & vin_s[c];
            diff = vip_s[c] ^ vin_s[c];
            nxt  = {1'b0, acc_q[c]};
            sd   = {1'b0, err_q[c]} + {1'b0, acc_q[c]};
            acc_d[c] = acc_q[c];
            err_d[c] = err_q[c];
            out_d[c] = out_q[c];
            oe_d[c]  = oe_q[c];
            sat_d[c] = sat_q[c];
`ifdef DIGI_OTA_DEBOUNCE_EN
            cnt_n    = 2'd0;
            cnt_d[c] = cnt_q[c];
            dir_d[c] = dir_q[c];
`endif
            if (!ena) begin
                oe_d[c] = 1'b0;
            end else if (mode != mode_q) begin
                // Mode switch restarts every channel from midscale.
                acc_d[c] = MID;
                err_d[c] = '0;
                out_d[c] = 1'b0;
                oe_d[c]  = 1'b0;
                sat_d[c] = 1'b0;
`ifdef DIGI_OTA_DEBOUNCE_EN
                cnt_d[c] = 2'd0;
`endif
            end else if (!mode_q) begin
                oe_d[c]  = diff;
                sat_d[c] = 1'b0;
`ifdef DIGI_OTA_DEBOUNCE_EN
                if (diff) begin
                    if (cnt_q[c] != 2'd0 && dir_q[c] == up)
                        cnt_n = (cnt_q[c] == 2'd3) ? 2'd3 : cnt_q[c] + 2'd1;
                    else
                        cnt_n = 2'd1;
                    dir_d[c] = up;
                    if (cnt_n == 2'd3)
                        out_d[c] = up;
                end
                cnt_d[c] = cnt_n;
`else
                if (up)
                    out_d[c] = 1'b1;
                else if (dn)
                    out_d[c] = 1'b0;
`endif
            end else begin
                if (up) begin
                    nxt = {1'b0, acc_q[c]} + STEP_X;
                    if (nxt > MAX_X)
                        nxt = MAX_X;
                end else if (dn) begin
                    if ({1'b0, acc_q[c]} < STEP_X)
                        nxt = '0;
                    else
                        nxt = {1'b0, acc_q[c]} - STEP_X;
                end
                acc_d[c] = nxt[ACC_W-1:0];
                sat_d[c] = (nxt == '0) || (nxt == MAX_X);
                // Carry of err + acc is the first-order modulator bit.
                err_d[c] = sd[ACC_W-1:0];
                out_d[c] = sd[ACC_W];
                oe_d[c]  = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                vip_sync_q[i] <= '0;
                vin_sync_q[i] <= '0;
            end
            for (int c = 0; c < CHANNELS; c++) begin
                acc_q[c] <= MID;
                err_q[c] <= '0;
`ifdef DIGI_OTA_DEBOUNCE_EN
                cnt_q[c] <= 2'd0;
`endif
            end
`ifdef DIGI_OTA_DEBOUNCE_EN
            dir_q  <= '0;
`endif
            mode_q <= 1'b0;
            out_q  <= '0;
            oe_q   <= '0;
            sat_q  <= '0;
        end else begin
            vip_sync_q[0] <= vip;
            vin_sync_q[0] <= vin;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                vip_sync_q[i] <= vip_sync_q[i-1];
                vin_sync_q[i] <= vin_sync_q[i-1];
            end
            for (int c = 0; c < CHANNELS; c++) begin
                acc_q[c] <= acc_d[c];
                err_q[c] <= err_d[c];
`ifdef DIGI_OTA_DEBOUNCE_EN
                cnt_q[c] <= cnt_d[c];
`endif
            end
`ifdef DIGI_OTA_DEBOUNCE_EN
            dir_q  <= dir_d;
`endif
            mode_q <= mode_d;
            out_q  <= out_d;
            oe_q   <= oe_d;
            sat_q  <= sat_d;
        end
    end

endmodule
